// File: rtl/demux_striping.sv
// Stripes a serial word stream alternately onto two lanes; each completed
// lane pair is registered and held valid for two clk_2f cycles (one clk_f period).
module demux_striping #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_2f,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out0,
  output logic                  valid_out0,
  output logic [DATA_WIDTH-1:0] data_out1,
  output logic                  valid_out1,
  output logic                  pending
);

  // Handshake: a word is consumed on every edge where valid_in=1 (no ready,
  // no backpressure); valid_out0/valid_out1 mark a paired word set that the
  // consumer must take during the two cycles it is presented.
  typedef enum logic {
    WAIT0 = 1'b0,
    WAIT1 = 1'b1
  } state_e;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold0_q, hold0_d;
  logic                  hold_cnt_q, hold_cnt_d;
  logic [DATA_WIDTH-1:0] out0_q, out0_d;
  logic [DATA_WIDTH-1:0] out1_q, out1_d;
  logic                  valid_q, valid_d;
  logic                  pair_done;

  assign pair_done = valid_in && (state_q == WAIT1);

  always_comb begin
    state_d    = state_q;
    hold0_d    = hold0_q;
    hold_cnt_d = hold_cnt_q;
    out0_d     = out0_q;
    out1_d     = out1_q;
    valid_d    = valid_q;

    case (state_q)
      WAIT0: begin
        if (valid_in) begin
          hold0_d = data_in;
          state_d = WAIT1;
        end
      end
      WAIT1: begin
        if (valid_in) begin
          out0_d  = hold0_q;
          out1_d  = data_in;
          state_d = WAIT0;
        end
      end
      default: state_d = WAIT0;
    endcase

    // A new pair always restarts the two-cycle window, even mid-window.
    if (pair_done) begin
      valid_d    = 1'b1;
      hold_cnt_d = 1'b1;
    end else if (hold_cnt_q) begin
      hold_cnt_d = 1'b0;
    end else begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q    <= WAIT0;
      hold0_q    <= '0;
      hold_cnt_q <= 1'b0;
      out0_q     <= '0;
      out1_q     <= '0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      hold0_q    <= hold0_d;
      hold_cnt_q <= hold_cnt_d;
      out0_q     <= out0_d;
      out1_q     <= out1_d;
      valid_q    <= valid_d;
    end
  end

  // One valid register feeds both lanes so they can never be presented unpaired.
  assign data_out0  = out0_q;
  assign data_out1  = out1_q;
  assign valid_out0 = valid_q;
  assign valid_out1 = valid_q;
  assign pending    = (state_q == WAIT1);

endmodule

// File: tb/tb_demux_striping.sv
// Bench for demux_striping: table vectors, hand sequences for gap/odd/reset
// corners, and random traffic checked against a queue-based pairing model.
module tb_demux_striping;
  localparam int W = 32;

  logic         clk_2f = 1'b0;
  logic         reset;
  logic [W-1:0] data_in;
  logic         valid_in;
  logic [W-1:0] data_out0, data_out1;
  logic         valid_out0, valid_out1, pending;

  demux_striping #(.DATA_WIDTH(W)) dut (
    .clk_2f    (clk_2f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .data_out0 (data_out0),
    .valid_out0(valid_out0),
    .data_out1 (data_out1),
    .valid_out1(valid_out1),
    .pending   (pending)
  );

  always #5 clk_2f = ~clk_2f;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: accepted words queue up; every second word forms a pair
  // with the one ahead of it. A pair is shown for the two cycles after the edge
  // that completes it; data lanes keep the last pair afterwards.
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_a = '0, last_b = '0;
  int           age = 2;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_edge(input logic r, input logic v, input logic [W-1:0] d);
    if (r) begin
      exp_q.delete();
      last_a = '0;
      last_b = '0;
      age    = 2;
    end else begin
      if (age < 2) age++;
      if (v) begin
        exp_q.push_back(d);
        if (exp_q.size() == 2) begin
          last_a = exp_q.pop_front();
          last_b = exp_q.pop_front();
          age    = 0;
        end
      end
    end
  endtask

  // One clk_2f cycle: drive, let the edge happen, then compare against the model.
  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    logic ev;
    reset    = r;
    valid_in = v;
    data_in  = d;
    @(posedge clk_2f);
    model_edge(r, v, d);
    @(negedge clk_2f);
    ev = (age < 2);
    chk("model_valid0", W'(valid_out0), W'(ev));
    chk("model_valid1", W'(valid_out1), W'(ev));
    chk("model_data0", data_out0, last_a);
    chk("model_data1", data_out1, last_b);
    chk("model_pending", W'(pending), W'(exp_q.size() == 1));
  endtask

  typedef struct {
    logic         rst;
    logic         v;
    logic [W-1:0] d;
    logic         e_v;
    logic [W-1:0] e_d0;
    logic [W-1:0] e_d1;
    logic         e_pend;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic v, input logic [W-1:0] d, input logic ev,
                     input logic [W-1:0] e0, input logic [W-1:0] e1, input logic ep);
    vec_t x;
    x.rst = r; x.v = v; x.d = d; x.e_v = ev; x.e_d0 = e0; x.e_d1 = e1; x.e_pend = ep;
    tbl.push_back(x);
  endtask

  initial begin
    reset    = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;

    // Reset with live input, then the four-word streaming sequence.
    add(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    add(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    add(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    add(0, 0, 32'h0,         0, 0, 0, 0);
    add(0, 1, 32'hA0,        0, 0, 0, 1);
    add(0, 1, 32'hA1,        1, 32'hA0, 32'hA1, 0);
    add(0, 1, 32'hA2,        1, 32'hA0, 32'hA1, 1);
    add(0, 1, 32'hA3,        1, 32'hA2, 32'hA3, 0);
    add(0, 0, 32'h0,         1, 32'hA2, 32'hA3, 0);
    add(0, 0, 32'h0,         0, 32'hA2, 32'hA3, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].rst, tbl[i].v, tbl[i].d);
      chk("tbl_valid0", W'(valid_out0), W'(tbl[i].e_v));
      chk("tbl_valid1", W'(valid_out1), W'(tbl[i].e_v));
      chk("tbl_data0", data_out0, tbl[i].e_d0);
      chk("tbl_data1", data_out1, tbl[i].e_d1);
      chk("tbl_pending", W'(pending), W'(tbl[i].e_pend));
    end

    // Gap inside a pair: partner arrives after four idle cycles.
    step(0, 1, 32'h10);
    chk("gap_pend_first", W'(pending), 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 32'hDEAD);
      chk("gap_pend_idle", W'(pending), 1);
      chk("gap_valid_idle", W'(valid_out0), 0);
    end
    step(0, 1, 32'h11);
    chk("gap_d0", data_out0, 32'h10);
    chk("gap_d1", data_out1, 32'h11);
    chk("gap_valid_c6", W'(valid_out0 & valid_out1), 1);
    step(0, 0, 32'h0);
    chk("gap_valid_c7", W'(valid_out0 & valid_out1), 1);
    step(0, 0, 32'h0);
    chk("gap_valid_c8", W'(valid_out0 | valid_out1), 0);

    // Odd word count: third word waits for a fourth.
    step(0, 1, 32'h1);
    step(0, 1, 32'h2);
    step(0, 1, 32'h3);
    chk("odd_pair_d0", data_out0, 32'h1);
    chk("odd_pair_d1", data_out1, 32'h2);
    for (int i = 0; i < 5; i++) step(0, 0, 32'h0);
    chk("odd_pend_held", W'(pending), 1);
    chk("odd_valid_low", W'(valid_out0), 0);
    step(0, 1, 32'h4);
    chk("odd_late_d0", data_out0, 32'h3);
    chk("odd_late_d1", data_out1, 32'h4);

    // Reset mid-pair discards the held lane 0 word.
    step(0, 0, 32'h0);
    step(0, 1, 32'h55);
    step(1, 0, 32'h0);
    chk("rst_mid_pend", W'(pending), 0);
    step(0, 1, 32'h66);
    step(0, 1, 32'h77);
    chk("rst_mid_d0", data_out0, 32'h66);
    chk("rst_mid_d1", data_out1, 32'h77);
    chk("rst_mid_valid", W'(valid_out0), 1);

    // Random traffic against the model, with rare resets.
    for (int i = 0; i < 1500; i++) begin
      logic r, v;
      r = ($urandom_range(0, 199) == 0);
      v = ($urandom_range(0, 9) < 6);
      step(r, v, $urandom());
      chk("rand_lanes_equal", W'(valid_out0), W'(valid_out1));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
